// File: rtl/hack_bus_pkg.sv
// Shared definitions for the Hack bus transaction sequencer.
// Slave-select codes match the upstream address decoder.
package hack_bus_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RAM_AW = 14;

    localparam logic [2:0] SEL_RAM  = 3'b000;
    localparam logic [2:0] SEL_IO   = 3'b010;
    localparam logic [2:0] SEL_NONE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_RAM_CAP,
        ST_IO_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/hack_bus_ctrl_if.sv
// CPU, RAM and IO signal bundle around the bus controller.
// master = the controller, slave = the CPU/slave environment.
interface hack_bus_ctrl_if
    import hack_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RAM_AW = DEF_RAM_AW
);
    logic              cpu_req;
    logic              cpu_we;
    logic [15:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        slave_sel;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              bus_err;

    logic              ram_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              io_en;
    logic              io_we;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_ready;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slave_sel,
        output cpu_ack, cpu_rdata, bus_err,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output io_en, io_we, io_wdata,
        input  io_rdata, io_ready
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slave_sel,
        input  cpu_ack, cpu_rdata, bus_err,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  io_en, io_we, io_wdata,
        output io_rdata, io_ready
    );

endinterface

// File: rtl/hack_bus_timeout_ctr.sv
// Saturating 8-bit wait counter; expired flags the cycle whose
// count would reach the limit.
module hack_bus_timeout_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_cnt;
    logic [8:0] w_next;

    assign w_next    = {1'b0, r_cnt} + 9'd1;
    assign o_expired = i_en && (w_next >= {1'b0, i_limit});

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/hack_bus_ctrl.sv
// Hack bus sequencer: runs one req/ack transaction to RAM or IO
// per CPU request, flagging unmapped selects and IO timeouts.
module hack_bus_ctrl
    import hack_bus_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_AW     = DEF_RAM_AW,
    parameter int IO_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    hack_bus_ctrl_if.master bus
);

    state_t            r_state;
    logic              r_we;
    logic              r_io_done;
    logic              r_err;
    logic [DATA_W-1:0] r_cap;

    logic              r_cpu_ack;
    logic              r_bus_err;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_io_en;
    logic              r_io_we;
    logic [DATA_W-1:0] r_io_wdata;

    logic w_sel_ram;
    logic w_sel_io;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_tmo_exp;

    assign w_sel_ram = (bus.slave_sel == SEL_RAM);
    assign w_sel_io  = (bus.slave_sel == SEL_IO);
    assign w_tmo_clr = (r_state == ST_IDLE);
    assign w_tmo_en  = (r_state == ST_IO_WAIT) && !r_io_done;

    hack_bus_timeout_ctr u_tmo (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmo_clr),
        .i_en      (w_tmo_en),
        .i_limit   (8'(IO_TIMEOUT)),
        .o_expired (w_tmo_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_io_done   <= 1'b0;
            r_err       <= 1'b0;
            r_cap       <= '0;
            r_cpu_ack   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_io_en     <= 1'b0;
            r_io_we     <= 1'b0;
            r_io_wdata  <= '0;
        end else begin
            r_cpu_ack   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cpu_rdata <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        r_we <= bus.cpu_we;
                        unique case (1'b1)
                            w_sel_ram: begin
                                r_ram_en    <= 1'b1;
                                r_ram_we    <= bus.cpu_we;
                                r_ram_addr  <= bus.cpu_addr[RAM_AW-1:0];
                                r_ram_wdata <= bus.cpu_wdata;
                                r_state     <= ST_RAM_ACC;
                            end
                            w_sel_io: begin
                                r_io_en    <= 1'b1;
                                r_io_we    <= bus.cpu_we;
                                r_io_wdata <= bus.cpu_wdata;
                                r_io_done  <= 1'b0;
                                r_state    <= ST_IO_WAIT;
                            end
                            default: begin
                                // unmapped or illegal code: no strobe
                                r_cpu_ack <= 1'b1;
                                r_bus_err <= 1'b1;
                                r_state   <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_RAM_ACC: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_state  <= ST_RAM_CAP;
                end
                ST_RAM_CAP: begin
                    r_cpu_ack   <= 1'b1;
                    r_cpu_rdata <= r_we ? '0 : bus.ram_rdata;
                    r_state     <= ST_RESP;
                end
                ST_IO_WAIT: begin
                    // completion is captured first, acked next cycle
                    if (r_io_done) begin
                        r_cpu_ack   <= 1'b1;
                        r_cpu_rdata <= r_cap;
                        r_bus_err   <= r_err;
                        r_io_done   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (bus.io_ready) begin
                        r_io_en   <= 1'b0;
                        r_io_we   <= 1'b0;
                        r_cap     <= r_we ? '0 : bus.io_rdata;
                        r_err     <= 1'b0;
                        r_io_done <= 1'b1;
                    end else if (w_tmo_exp) begin
                        r_io_en   <= 1'b0;
                        r_io_we   <= 1'b0;
                        r_cap     <= '0;
                        r_err     <= 1'b1;
                        r_io_done <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.bus_err   = r_bus_err;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.io_en     = r_io_en;
    assign bus.io_we     = r_io_we;
    assign bus.io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_hack_bus_ctrl.sv
// Bench for hack_bus_ctrl: directed table, corner sequences and
// random transactions against a transaction-level model.
module tb_hack_bus_ctrl;

    localparam int TMO = 8;

    logic clk;
    logic reset;

    hack_bus_ctrl_if #(.DATA_W(16), .RAM_AW(14)) bus ();

    hack_bus_ctrl #(
        .DATA_W     (16),
        .RAM_AW     (14),
        .IO_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM slave: data valid the cycle after ram_en.
    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  sel;
        int          io_dly;
        logic [15:0] io_data;
        int          e_lat;
        logic [15:0] e_rdata;
        logic        e_err;
        int          e_ram;
        int          e_io;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] shadow [int];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic we, logic [15:0] addr,
        logic [15:0] wd, logic [2:0] sel, int dly, logic [15:0] iod,
        int lat, logic [15:0] rd, logic err, int nram, int nio);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.sel = sel;
        v.io_dly = dly; v.io_data = iod;
        v.e_lat = lat; v.e_rdata = rd; v.e_err = err;
        v.e_ram = nram; v.e_io = nio;
        return v;
    endfunction

    // Transaction-level expectations from the bus rules.
    function automatic vec_t model(vec_t v);
        vec_t r = v;
        r.e_rdata = 16'h0; r.e_err = 1'b0; r.e_ram = 0; r.e_io = 0;
        if (v.sel == 3'b000) begin
            r.e_lat = 3;
            r.e_ram = 1;
            if (!v.we) r.e_rdata = shadow[int'(v.addr[13:0])];
        end else if (v.sel == 3'b010) begin
            if (v.io_dly >= 1 && v.io_dly <= TMO) begin
                r.e_lat = v.io_dly + 2;
                r.e_io  = v.io_dly;
                if (!v.we) r.e_rdata = v.io_data;
            end else begin
                r.e_lat = TMO + 2;
                r.e_io  = TMO;
                r.e_err = 1'b1;
            end
        end else begin
            r.e_lat = 1;
            r.e_err = 1'b1;
        end
        return r;
    endfunction

    // mode 0: drop req on ack, 1: drop req after cycle 1, 2: hold req
    task automatic run_txn(input vec_t v, input string nm, input int mode);
        int cyc = 0;
        int nram = 0;
        int nio = 0;
        bit got = 0;
        logic [15:0] rd = 16'h0;
        logic er = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        bus.slave_sel = v.sel;
        while (!got && cyc < 64) begin
            tick();
            cyc++;
            if (bus.ram_en) begin
                nram++;
                chk({nm, ".ram_we"}, 32'(bus.ram_we), 32'(v.we));
                chk({nm, ".ram_addr"}, 32'(bus.ram_addr), 32'(v.addr[13:0]));
                chk({nm, ".ram_wdata"}, 32'(bus.ram_wdata), 32'(v.wdata));
            end
            if (bus.io_en) begin
                nio++;
                chk({nm, ".io_we"}, 32'(bus.io_we), 32'(v.we));
                chk({nm, ".io_wdata"}, 32'(bus.io_wdata), 32'(v.wdata));
            end
            bus.io_ready = bus.io_en && (nio == v.io_dly);
            bus.io_rdata = bus.io_ready ? v.io_data : 16'hDEAD;
            if (bus.cpu_ack) begin
                got = 1;
                rd  = bus.cpu_rdata;
                er  = bus.bus_err;
            end
            if (mode == 1 && cyc == 1) bus.cpu_req = 1'b0;
        end
        bus.io_ready = 1'b0;
        if (mode != 2) bus.cpu_req = 1'b0;
        chk({nm, ".ack_seen"}, 32'(got), 32'd1);
        chk({nm, ".latency"}, 32'(cyc), 32'(v.e_lat));
        chk({nm, ".rdata"}, 32'(rd), 32'(v.e_rdata));
        chk({nm, ".bus_err"}, 32'(er), 32'(v.e_err));
        chk({nm, ".ram_en_cycles"}, 32'(nram), 32'(v.e_ram));
        chk({nm, ".io_en_cycles"}, 32'(nio), 32'(v.e_io));
        if (v.sel == 3'b000 && v.we) shadow[int'(v.addr[13:0])] = v.wdata;
        if (mode != 2) begin
            tick();
            chk({nm, ".ack_low"}, 32'(bus.cpu_ack), 32'd0);
            chk({nm, ".rdata_low"}, 32'(bus.cpu_rdata), 32'd0);
            chk({nm, ".strobes_low"}, 32'({bus.ram_en, bus.io_en}), 32'd0);
        end
    endtask

    vec_t tbl [9];
    vec_t v;

    initial begin
        tbl[0] = mk(1, 16'h0123, 16'hBEEF, 3'b000, 0, 16'h0,    3, 16'h0,    0, 1, 0);
        tbl[1] = mk(0, 16'h0123, 16'h0,    3'b000, 0, 16'h0,    3, 16'hBEEF, 0, 1, 0);
        tbl[2] = mk(0, 16'h4000, 16'h0,    3'b010, 5, 16'h00A5, 7, 16'h00A5, 0, 0, 5);
        tbl[3] = mk(1, 16'h6000, 16'h1111, 3'b100, 0, 16'h0,    1, 16'h0,    1, 0, 0);
        tbl[4] = mk(0, 16'h4000, 16'h0,    3'b010, 0, 16'h1234, 10, 16'h0,   1, 0, 8);
        tbl[5] = mk(0, 16'h4000, 16'h0,    3'b010, 8, 16'h5A5A, 10, 16'h5A5A, 0, 0, 8);
        tbl[6] = mk(0, 16'h0123, 16'h0,    3'b011, 0, 16'h0,    1, 16'h0,    1, 0, 0);
        tbl[7] = mk(1, 16'h4000, 16'h7777, 3'b010, 1, 16'hFFFF, 3, 16'h0,    0, 0, 1);
        tbl[8] = mk(0, 16'h4000, 16'h0,    3'b010, 9, 16'hABCD, 10, 16'h0,   1, 0, 8);

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0;
        bus.cpu_wdata = 16'h0; bus.slave_sel = 3'b000;
        bus.io_rdata = 16'h0; bus.io_ready = 1'b0;
        repeat (3) tick();
        chk("rst.ack_err", 32'({bus.cpu_ack, bus.bus_err}), 32'd0);
        chk("rst.strobes", 32'({bus.ram_en, bus.ram_we, bus.io_en, bus.io_we}), 32'd0);
        chk("rst.rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst.ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst.wdata", 32'({bus.ram_wdata, bus.io_wdata}), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i), 0);
        end

        // Reset while waiting on IO: strobe drops, no ack follows.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4000;
        bus.slave_sel = 3'b010;
        repeat (3) tick();
        chk("rstio.io_en_before", 32'(bus.io_en), 32'd1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        chk("rstio.io_en_after", 32'(bus.io_en), 32'd0);
        chk("rstio.ack_after", 32'(bus.cpu_ack), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstio.no_ack", 32'({bus.cpu_ack, bus.io_en}), 32'd0);
        end
        v = mk(0, 16'h0123, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 0, 0, 0);
        run_txn(model(v), "rstio.ram_read", 0);

        // Back-to-back: req held across ack starts a second access.
        v = model(mk(0, 16'h0123, 16'h0, 3'b000, 0, 16'h0, 0, 16'h0, 0, 0, 0));
        run_txn(v, "b2b.first", 2);
        tick();
        chk("b2b.idle_ack", 32'(bus.cpu_ack), 32'd0);
        run_txn(v, "b2b.second", 0);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 9);
            v.we = 1'($urandom_range(0, 1));
            v.wdata = 16'($urandom);
            v.io_data = 16'($urandom);
            v.io_dly = $urandom_range(0, 10);
            v.addr = 16'($urandom_range(0, 15));
            if (k <= 4) begin
                v.sel = 3'b000;
                if (!shadow.exists(int'(v.addr[13:0]))) v.we = 1'b1;
            end else if (k <= 7) begin
                v.sel = 3'b010;
                v.addr = 16'h4000;
            end else if (k == 8) begin
                v.sel = 3'b100;
                v.addr = 16'h6000 | v.addr;
            end else begin
                case ($urandom_range(0, 4))
                    0: v.sel = 3'b001;
                    1: v.sel = 3'b011;
                    2: v.sel = 3'b101;
                    3: v.sel = 3'b110;
                    default: v.sel = 3'b111;
                endcase
            end
            run_txn(model(v), $sformatf("rnd%0d", i), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
